stream_mux_2x1: RTL
===================

# stream_mux_2x1

Two-input, one-output streaming multiplexer with valid/ready handshakes. It is the merging counterpart to the team's 1-to-2 demultiplexer: it recombines two source streams onto one sink. Arbitration is round-robin and packet-locked, so a multi-beat packet is never interleaved. Each output beat carries a select tag that records which input it came from, so a downstream demux can route on it.

## Interface
Parameters:
- DATA_W, 8, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Asserts asynchronously and releases synchronously to clk via an external synchronizer.
- a0_valid  input  1  channel 0 beat valid.
- a0_data  input  DATA_W  channel 0 payload.
- a0_last  input  1  channel 0 end-of-packet marker.
- a0_ready  output  1  channel 0 beat accepted this cycle when high together with a0_valid.
- a1_valid, a1_data, a1_last, a1_ready: same as channel 0, for channel 1.
- y_valid  output  1  output beat valid (registered).
- y_data  output  DATA_W  output payload (registered).
- y_last  output  1  output end-of-packet marker (registered).
- y_sel  output  1  source channel of the output beat: 0 = a0, 1 = a1 (registered).
- y_ready  input  1  sink accepts the output beat.

## Operation
- Output stage: a single register holding y_valid, y_data, y_last and y_sel.
  - It can load when `!y_valid || y_ready`. Call this `load_ok`.
- Grant:
  - In IDLE with one input valid, that input is granted.
  - In IDLE with both inputs valid, the input selected by the priority pointer `prio` is granted.
  - In LOCK0 the grant is fixed to 0; in LOCK1 it is fixed to 1, regardless of the valid signals.
- Handshake outputs: `aN_ready = load_ok && (grant == N)`. Only one ready is high in any cycle. Ready may depend combinationally on y_ready.
- Input handshake: a beat transfers when `aN_valid && aN_ready`. On transfer, the output register loads {1, aN_data, aN_last, N}.
- Output handshake: when y_valid is high, y_ready is high, and no new beat loads, y_valid clears to 0 on the next edge.
- State machine (IDLE, LOCK0, LOCK1):
  - IDLE: a transfer from N with last=0 moves to LOCKN. A transfer with last=1 stays in IDLE.
  - LOCKN: a transfer from N with last=1 returns to IDLE. Any other cycle stays in LOCKN. The other channel's ready is held low throughout.
- Priority pointer: on every transfer with last=1 from channel N, `prio` is set to `~N`.
- Inputs must hold valid, data and last stable until accepted. Withdrawing valid before acceptance is a protocol error and the behaviour is not defined.

## Timing
- Reset values:
  - y_valid=0, y_data=0, y_last=0, y_sel=0.
  - State = IDLE, prio = 0, so channel 0 wins the first contention.
  - Both aN_ready are 0 during reset.
- Latency: 1 cycle. A beat accepted at edge k is visible on y_* after edge k.
- Throughput: 1 beat per cycle while y_ready is held high, including back-to-back beats from alternating channels.
- Backpressure: while y_valid=1 and y_ready=0:
  - y_* hold stable.
  - Both aN_ready are 0.
  - State and prio are frozen.
- Simultaneous events: a new beat may load on the same edge the held beat drains (y_valid stays 1).
- Reset mid-packet: the lock and any held beat are discarded immediately. After release, the block restarts in IDLE with prio=0. Flushing the upstream sources is their owner's responsibility.
- No combinational path from aN_valid to y_*.
- Combinational paths that do exist: y_ready to aN_ready, and aN_valid to the other channel's aN_ready (IDLE grant only).

## Structure
- Shared package stream_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2;
  - the default DATA_W constant, shared with the demux.
- One sub-module, rr_arb2: a 2-way round-robin grant.
  - Inputs: req[1:0], prio, lock, lock_id.
  - Output: grant.
  - Purely combinational.
- stream_mux_2x1 contains the FSM, the prio register, the output register and the ready logic.

## Test plan
- Reset: assert rst_n=0 mid-stream. Required: y_valid=0, y_data=8'h00, y_sel=0 and both readys 0 immediately. After release, the first contention goes to channel 0.
- Single beats, contention: a0=8'hA0 and a1=8'hB1 both valid with last=1, y_ready=1. Required: outputs A0/sel0, then B1/sel1 on consecutive cycles, then alternating while both stay valid.
- Packet lock: a0 sends 3 beats 8'h10, 8'h11, 8'h12 (last on the third) while a1 holds 8'h55 valid. Required: 10, 11, 12 with sel=0, then 55 with sel=1. a1_ready stays 0 until 12 is accepted.
- Backpressure: hold y_ready=0 for 4 cycles with a beat in the output stage. Required: y_data is stable, both readys are 0, and no beats are lost or duplicated when y_ready returns high.
- Full-rate streaming: 16 random beats per channel with random last, y_ready=1. Required: the output sequence per y_sel equals the input sequence per channel, and packets are contiguous.
- Random y_ready toggling at 50%: same scoreboard check as full-rate streaming, and the handshake protocol assertions never fire.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the 2-way stream mux/demux family.
package stream_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; a held lock overrides the request-based choice.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       lock,
  input  logic       lock_id,
  output logic       grant
);

  always_comb begin
    grant = prio;
    if (lock) begin
      grant = lock_id;
    end else begin
      unique case (req)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        default: grant = prio;
      endcase
    end
  end

endmodule

// File: rtl/stream_mux_2x1.sv
// Packet-locked round-robin 2:1 stream merge with a registered output stage.
//
// state    | meaning
// ST_IDLE  | no packet in flight, arbitrate between valid inputs
// ST_LOCK0 | packet from a0 in progress, a1 held off until a0 sends last
// ST_LOCK1 | packet from a1 in progress, a0 held off until a1 sends last
module stream_mux_2x1
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a0_valid,
  input  logic [DATA_W-1:0] a0_data,
  input  logic              a0_last,
  output logic              a0_ready,
  input  logic              a1_valid,
  input  logic [DATA_W-1:0] a1_data,
  input  logic              a1_last,
  output logic              a1_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              y_sel,
  input  logic              y_ready
);

  state_e state;
  logic   prio;
  logic   grant;
  logic   load_ok;
  logic   xfer;
  logic   xfer_last;

  rr_arb2 u_arb (
    .req     ({a1_valid, a0_valid}),
    .prio    (prio),
    .lock    (state != ST_IDLE),
    .lock_id (state == ST_LOCK1),
    .grant   (grant)
  );

  assign load_ok = !y_valid || y_ready;

  // rst_n gates ready so no source sees acceptance while the block is held in reset
  assign a0_ready = rst_n && load_ok && !grant;
  assign a1_ready = rst_n && load_ok && grant;

  assign xfer      = (a0_valid && a0_ready) || (a1_valid && a1_ready);
  assign xfer_last = grant ? a1_last : a0_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      prio    <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      y_sel   <= 1'b0;
    end else begin
      if (xfer) begin
        y_valid <= 1'b1;
        y_data  <= grant ? a1_data : a0_data;
        y_last  <= xfer_last;
        y_sel   <= grant;
        if (xfer_last) begin
          prio <= ~grant;
        end
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (xfer && !xfer_last) begin
            state <= grant ? ST_LOCK1 : ST_LOCK0;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (xfer && xfer_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
